mul_pipe_unit: RTL and testbench
================================

Name: mul_pipe_unit

Overview:
- Parametrised, fully pipelined integer multiply/multiply-accumulate unit for the EX stage.
- Successor to the fixed 32-bit multicycle multiplier. Width and pipeline depth are configurable.
- Valid/ready handshake replaces the multicycle/ready pair. Supports back-pressure, flush and a tag passthrough, and sustains one op per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (8..64, even).
- STAGES, 2, pipeline depth = latency in cycles from accept to out_valid_o (1..4).
- TAG_W, 4, width of the opaque tag carried alongside each op.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  op presented
- in_ready_o  out  1  unit accepts op this cycle
- op_i  in  3  0=MUL, 1=MULH (s*s), 2=MULHSU (s*u), 3=MULHU (u*u), 4=MAC; 5..7 reserved
- operand_a_i  in  WIDTH  multiplicand
- operand_b_i  in  WIDTH  multiplier
- operand_c_i  in  WIDTH  accumulator addend (MAC only)
- tag_i  in  TAG_W  opaque tag
- flush_i  in  1  kill all in-flight ops
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer takes result
- result_o  out  WIDTH  result
- tag_o  out  TAG_W  tag of result
- illegal_o  out  1  result came from a reserved opcode (result_o = 0)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All stage valid bits cleared.
  - out_valid_o=0, result_o=0, tag_o=0, illegal_o=0.
  - Data registers may be cleared or left; outputs are gated to 0 when invalid.
  - Reset mid-operation discards every in-flight op.
- Global advance enable: adv = !out_valid_o || out_ready_i.
  - in_ready_o = adv, a combinational function of out_valid_o and out_ready_i only, never of in_valid_i.
  - Op accepted when in_valid_i && in_ready_o.
- On adv, every stage shifts one step. Stage 0 loads the accepted op, or a bubble if none was accepted.
- When !adv, all stages hold. out_valid_o, result_o, tag_o and illegal_o stay stable until the handshake completes.
- Latency: an op accepted at edge N gives out_valid_o=1 after edge N+STAGES-1, absent stalls.
- Throughput: 1 op/cycle while out_ready_i=1. Bubbles propagate as invalid slots.
- Arithmetic: full 2*WIDTH product P, computed with a signed (WIDTH+1)-bit extension of each operand.
  - MUL: P[WIDTH-1:0].
  - MULH: a signed, b signed, P[2W-1:W].
  - MULHSU: a signed, b unsigned, P[2W-1:W].
  - MULHU: both unsigned, P[2W-1:W].
  - MAC: (P[W-1:0] + c) mod 2^WIDTH. Signedness is irrelevant for the low half.
- Partial-product reduction may be split across stages freely. Only the final stage output is architecturally visible.
- Boundary values, WIDTH=32:
  - MULH 0x80000000*0x80000000 = 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFF.
  - MAC wraps, no carry out.
- Reserved op: accepted normally, traverses the pipe, then result_o=0 and illegal_o=1 with out_valid_o.
- flush_i=1 at an edge:
  - All stage valid bits cleared, including any output held under stall. out_valid_o=0 next cycle.
  - An in_valid_i op in the same cycle is dropped, even though in_ready_o was high.
  - Flush takes priority over adv. Reset takes priority over flush.
- Simultaneous out handshake and new accept in the same cycle: both occur with no bubble inserted.
- tag_o always equals the tag accepted with the op currently on result_o.

Optional Feature:
- Macro: MUL_PIPE_SAT_EN.
- Defined:
  - op 5 = MACS, signed saturating multiply-accumulate. The exact signed value a*b+c is clamped to [-2^(W-1), 2^(W-1)-1].
  - Extra output port sat_o (1 bit, 0 on reset) is set with out_valid_o when clamping occurred.
  - op 5 is no longer illegal.
- Not defined:
  - op 5 is reserved (illegal_o=1, result 0).
  - sat_o port absent.

Test Plan:
- WIDTH=32, STAGES=2, out_ready_i=1: MUL 7*6 tag 3 -> out_valid_o one cycle after accept edge, result 42, tag_o 3.
- Back-to-back: MULH 0x80000000*0x80000000, MULHU 0xFFFFFFFF*0xFFFFFFFF, MULHSU 0xFFFFFFFF*0xFFFFFFFF on consecutive cycles -> results 0x40000000, 0xFFFFFFFE, 0xFFFFFFFF on consecutive cycles, no bubbles.
- Back-pressure: MAC 0x10000*0x10000+5 issued, out_ready_i held 0 for 4 cycles -> in_ready_o=0 and result_o=0x00000005 stable throughout; consumed on the first cycle out_ready_i=1, next op follows.
- Flush: 2 ops in flight and in_valid_i=1 with flush_i=1 -> out_valid_o=0 the next cycle and no result ever appears for the 3 ops.
- Reserved op 6, then synchronous rst_n=0 mid-flight on a second op -> first op gives illegal_o=1 result 0; after reset all outputs 0 and the second op never emerges.
- MUL_PIPE_SAT_EN: MACS 0x7FFFFFFF*2+0 -> result 0x7FFFFFFF, sat_o=1; MACS -3*4+2 -> 0xFFFFFFF6, sat_o=0.

Source files
------------

// File: rtl/mul_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe_unit
// Purpose  : Parametrised, fully pipelined integer multiply / multiply-
//            accumulate unit for the EX stage. One op per cycle with a
//            valid/ready handshake, global back-pressure, flush and an
//            opaque tag carried alongside every op.
//
// Parameters
//   WIDTH   operand/result width in bits (8..64, even)
//   STAGES  latency in cycles from accept edge to out_valid_o (1..4)
//   TAG_W   width of the opaque tag
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   in_valid_i   op presented
//   in_ready_o   unit accepts op this cycle (depends only on output state)
//   op_i         0=MUL 1=MULH 2=MULHSU 3=MULHU 4=MAC 5=MACS(opt) else reserved
//   operand_a_i  multiplicand
//   operand_b_i  multiplier
//   operand_c_i  accumulator addend (MAC/MACS)
//   tag_i        opaque tag
//   flush_i      kill every in-flight op (and any op offered this cycle)
//   out_valid_o  result valid
//   out_ready_i  consumer takes result
//   result_o     result (0 when not valid or reserved opcode)
//   tag_o        tag of the op on result_o
//   illegal_o    result came from a reserved opcode
//   sat_o        (MUL_PIPE_SAT_EN only) MACS result was clamped
//
// Optional feature macro: MUL_PIPE_SAT_EN
//   Defined   : op 5 is MACS (signed saturating a*b+c), sat_o port present.
//   Undefined : op 5 is reserved, no sat_o port.
//
// Revision : 1.0  initial parametrised pipelined release
// ============================================================================
module mul_pipe_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic [WIDTH-1:0] operand_c_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             illegal_o
`ifdef MUL_PIPE_SAT_EN
    ,
    output logic             sat_o
`endif
);

    // ------------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_MAC    = 3'd4;
`ifdef MUL_PIPE_SAT_EN
    localparam logic [2:0] c_OP_MACS   = 3'd5;
`endif

    // With more than one stage, stage 0 holds the raw operands and the
    // arithmetic sits between stage 0 and the first result stage, so the
    // multiplier never sees the input pins directly. With a single stage
    // the arithmetic has to sit in front of the only register.
    localparam int c_NRES = (STAGES > 1) ? (STAGES - 1) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             illegal;
`ifdef MUL_PIPE_SAT_EN
        logic             sat;
`endif
    } res_t;

    // ------------------------------------------------------------------------
    // Arithmetic. Each operand is viewed as a (WIDTH+1)-bit signed value
    // (sign bit = MSB for signed ops, 0 otherwise); sign-extending that to
    // 2*WIDTH and multiplying modulo 2^(2*WIDTH) gives exactly the low
    // 2*WIDTH bits of the true product.
    // ------------------------------------------------------------------------
    function automatic res_t f_compute(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c
    );
        logic               a_sgn;
        logic               b_sgn;
        logic [2*WIDTH-1:0] a_x;
        logic [2*WIDTH-1:0] b_x;
        logic [2*WIDTH-1:0] prod;
`ifdef MUL_PIPE_SAT_EN
        logic [2*WIDTH:0]   acc;
        logic               fits;
`endif
        res_t               r;

        r     = '0;
        a_sgn = (op == c_OP_MULH) || (op == c_OP_MULHSU);
        b_sgn = (op == c_OP_MULH);
`ifdef MUL_PIPE_SAT_EN
        if (op == c_OP_MACS) begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
        end
`endif
        a_x  = {{WIDTH{a_sgn & a[WIDTH-1]}}, a};
        b_x  = {{WIDTH{b_sgn & b[WIDTH-1]}}, b};
        prod = a_x * b_x;

        case (op)
            c_OP_MUL: begin
                r.res = prod[WIDTH-1:0];
            end
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: begin
                r.res = prod[2*WIDTH-1:WIDTH];
            end
            c_OP_MAC: begin
                r.res = prod[WIDTH-1:0] + c;
            end
`ifdef MUL_PIPE_SAT_EN
            c_OP_MACS: begin
                // A signed WIDTH x WIDTH product always fits in 2*WIDTH
                // signed bits; one more bit holds the addend exactly.
                acc  = {prod[2*WIDTH-1], prod} + {{(WIDTH+1){c[WIDTH-1]}}, c};
                // Representable in WIDTH signed bits iff every bit from the
                // top down to the result sign bit agrees.
                fits = (&acc[2*WIDTH:WIDTH-1]) || (~|acc[2*WIDTH:WIDTH-1]);
                if (fits) begin
                    r.res = acc[WIDTH-1:0];
                end else begin
                    r.sat = 1'b1;
                    r.res = acc[2*WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`endif
            default: begin
                r.illegal = 1'b1;   // reserved opcode: result stays 0
            end
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Handshake. Every stage moves together, so the unit can take a new op
    // exactly when the output slot is empty or being drained this cycle.
    // ------------------------------------------------------------------------
    logic w_adv;
    logic w_accept;

    assign w_adv      = !out_valid_o || out_ready_i;
    assign in_ready_o = w_adv;
    assign w_accept   = in_valid_i && w_adv;

    // Feed into the first result stage
    logic             w_first_v;
    res_t             w_first_d;
    logic [TAG_W-1:0] w_first_tag;

    generate
        if (STAGES > 1) begin : g_op_stage
            logic             r_op_v;
            logic [2:0]       r_op;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_c;
            logic [TAG_W-1:0] r_tag;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_op_v <= 1'b0;
                    r_op   <= '0;
                    r_a    <= '0;
                    r_b    <= '0;
                    r_c    <= '0;
                    r_tag  <= '0;
                end else if (flush_i) begin
                    r_op_v <= 1'b0;
                end else if (w_adv) begin
                    // A cycle without an accepted op loads a bubble.
                    r_op_v <= w_accept;
                    r_op   <= op_i;
                    r_a    <= operand_a_i;
                    r_b    <= operand_b_i;
                    r_c    <= operand_c_i;
                    r_tag  <= tag_i;
                end
            end

            assign w_first_v   = r_op_v;
            assign w_first_d   = f_compute(r_op, r_a, r_b, r_c);
            assign w_first_tag = r_tag;
        end else begin : g_no_op_stage
            assign w_first_v   = w_accept;
            assign w_first_d   = f_compute(op_i, operand_a_i, operand_b_i, operand_c_i);
            assign w_first_tag = tag_i;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Result stages; the last one is the architectural output register.
    // ------------------------------------------------------------------------
    logic             r_res_v   [c_NRES];
    res_t             r_res_d   [c_NRES];
    logic [TAG_W-1:0] r_res_tag [c_NRES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NRES; i++) begin
                r_res_v[i]   <= 1'b0;
                r_res_d[i]   <= '0;
                r_res_tag[i] <= '0;
            end
        end else if (flush_i) begin
            // Flush wins over advance and also drops a stalled output.
            for (int i = 0; i < c_NRES; i++) begin
                r_res_v[i] <= 1'b0;
            end
        end else if (w_adv) begin
            r_res_v[0]   <= w_first_v;
            r_res_d[0]   <= w_first_d;
            r_res_tag[0] <= w_first_tag;
            for (int i = 1; i < c_NRES; i++) begin
                r_res_v[i]   <= r_res_v[i-1];
                r_res_d[i]   <= r_res_d[i-1];
                r_res_tag[i] <= r_res_tag[i-1];
            end
        end
    end

    // Data registers of bubbles and flushed slots are stale, so the visible
    // outputs are gated by the valid bit.
    assign out_valid_o = r_res_v[c_NRES-1];
    assign result_o    = out_valid_o ? r_res_d[c_NRES-1].res     : '0;
    assign tag_o       = out_valid_o ? r_res_tag[c_NRES-1]       : '0;
    assign illegal_o   = out_valid_o ? r_res_d[c_NRES-1].illegal : 1'b0;
`ifdef MUL_PIPE_SAT_EN
    assign sat_o       = out_valid_o ? r_res_d[c_NRES-1].sat     : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_pipe_unit
// Purpose  : Self-checking bench for mul_pipe_unit (WIDTH=32). Accepted ops
//            are turned into expected results by a 64-bit arithmetic model
//            and queued; a monitor pops and compares on every output
//            handshake and checks handshake and stall rules every cycle.
//            Honours MUL_PIPE_SAT_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_pipe_unit;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [2:0]    op_i;
    logic [W-1:0]  operand_a_i;
    logic [W-1:0]  operand_b_i;
    logic [W-1:0]  operand_c_i;
    logic [TW-1:0] tag_i;
    logic          flush_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  result_o;
    logic [TW-1:0] tag_o;
    logic          illegal_o;
`ifdef MUL_PIPE_SAT_EN
    logic          sat_o;
`endif

    always #5 clk = ~clk;

    mul_pipe_unit #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .op_i       (op_i),
        .operand_a_i(operand_a_i),
        .operand_b_i(operand_b_i),
        .operand_c_i(operand_c_i),
        .tag_i      (tag_i),
        .flush_i    (flush_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .result_o   (result_o),
        .tag_o      (tag_o),
        .illegal_o  (illegal_o)
`ifdef MUL_PIPE_SAT_EN
        ,
        .sat_o      (sat_o)
`endif
    );

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic          ill;
        logic          sat;
    } exp_t;

    exp_t sb_q[$];
    int   hs_cyc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic on the op's meaning.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] c,
                                   input logic [TW-1:0] tag);
        longint          sa, sb, sc, sp;
        longint unsigned ua, ub, uc, up;
        logic [63:0]     full;
        exp_t            e;
        e.res = '0; e.tag = tag; e.ill = 1'b0; e.sat = 1'b0;
        sa = longint'($signed(a)); sb = longint'($signed(b)); sc = longint'($signed(c));
        ua = {32'b0, a};           ub = {32'b0, b};           uc = {32'b0, c};
        case (op)
            3'd0: begin up = ua * ub;              full = up; e.res = full[31:0];  end
            3'd1: begin sp = sa * sb;              full = sp; e.res = full[63:32]; end
            3'd2: begin sp = sa * $signed(ub);     full = sp; e.res = full[63:32]; end
            3'd3: begin up = ua * ub;              full = up; e.res = full[63:32]; end
            3'd4: begin up = ua * ub + uc;         full = up; e.res = full[31:0];  end
`ifdef MUL_PIPE_SAT_EN
            3'd5: begin
                sp = sa * sb + sc;
                if (sp > 64'sd2147483647) begin
                    e.res = 32'h7FFF_FFFF; e.sat = 1'b1;
                end else if (sp < -64'sd2147483648) begin
                    e.res = 32'h8000_0000; e.sat = 1'b1;
                end else begin
                    full = sp; e.res = full[31:0];
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard push side: one expected entry per accepted op.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n !== 1'b1 || flush_i === 1'b1) sb_q.delete();
            else if (in_valid_i && in_ready_o)
                sb_q.push_back(model(op_i, operand_a_i, operand_b_i, operand_c_i, tag_i));
        end
    end

    // Monitor: handshake rule, stall stability, spurious outputs, results.
    initial begin
        exp_t          e;
        logic          p_stall;
        logic [W-1:0]  p_res;
        logic [TW-1:0] p_tag;
        p_stall = 1'b0; p_res = '0; p_tag = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                p_stall = 1'b0;
            end else begin
                chk("in_ready_rule", in_ready_o, !out_valid_o || out_ready_i);
                if (p_stall) begin
                    chk("stall_valid",  out_valid_o, 1);
                    chk("stall_result", result_o, p_res);
                    chk("stall_tag",    tag_o, p_tag);
                end
                if (sb_q.size() == 0) begin
                    chk("spurious_valid", out_valid_o, 0);
                end else if (out_valid_o && out_ready_i && !flush_i) begin
                    e = sb_q.pop_front();
                    chk("result",  result_o,  e.res);
                    chk("tag",     tag_o,     e.tag);
                    chk("illegal", illegal_o, e.ill);
`ifdef MUL_PIPE_SAT_EN
                    chk("sat",     sat_o,     e.sat);
`endif
                    hs_cyc.push_back(cyc);
                end
                p_stall = out_valid_o && !out_ready_i && !flush_i;
                p_res   = result_o;
                p_tag   = tag_o;
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c, input logic [TW-1:0] tag);
        in_valid_i = v; op_i = op; operand_a_i = a; operand_b_i = b;
        operand_c_i = c; tag_i = tag;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 3'd0, '0, '0, '0, '0);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) idle(1);
        chk("drain_empty", sb_q.size(), 0);
        idle(2);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0;
        rst_n = 1'b0; in_valid_i = 1'b0; op_i = '0; operand_a_i = '0;
        operand_b_i = '0; operand_c_i = '0; tag_i = '0; flush_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_result",    result_o,    0);
        chk("rst_tag",       tag_o,       0);
        chk("rst_illegal",   illegal_o,   0);
        chk("rst_in_ready",  in_ready_o,  1);
`ifdef MUL_PIPE_SAT_EN
        chk("rst_sat",       sat_o,       0);
`endif
        rst_n = 1'b1;

        // Single MUL: latency and value
        drive(1'b1, 3'd0, 32'd7, 32'd6, 32'd0, 4'd3);
        for (int k = 0; k < S - 1; k++) begin
            chk("lat_early", out_valid_o, 0);
            idle(1);
        end
        chk("lat_valid",  out_valid_o, 1);
        chk("lat_result", result_o, 42);
        chk("lat_tag",    tag_o, 3);
        drain();

        // Back-to-back high-half boundary cases, no bubbles
        hs_cyc.delete();
        drive(1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'd0, 4'd1);
        t0 = cyc;
        drive(1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'd2);
        drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'd3);
        drain();
        chk("b2b_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("b2b_first",  hs_cyc[0], t0 + S - 1);
            chk("b2b_second", hs_cyc[1], hs_cyc[0] + 1);
            chk("b2b_third",  hs_cyc[2], hs_cyc[1] + 1);
        end

        // Back-pressure: MAC held four cycles, next op offered meanwhile
        hs_cyc.delete();
        out_ready_i = 1'b0;
        drive(1'b1, 3'd4, 32'h0001_0000, 32'h0001_0000, 32'd5, 4'd5);
        idle(S - 1);
        in_valid_i = 1'b1; op_i = 3'd0; operand_a_i = 32'd3; operand_b_i = 32'd3;
        operand_c_i = 32'd0; tag_i = 4'd6;
        for (int k = 0; k < 4; k++) begin
            chk("bp_in_ready",  in_ready_o, 0);
            chk("bp_out_valid", out_valid_o, 1);
            chk("bp_result",    result_o, 32'h5);
            @(posedge clk); #1;
        end
        t0 = cyc;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        drain();
        chk("bp_count", hs_cyc.size(), 2);
        if (hs_cyc.size() == 2) begin
            chk("bp_consume_cycle", hs_cyc[0], t0);
            chk("bp_next_cycle",    hs_cyc[1], t0 + S);
        end

        // Flush with two ops in flight plus one offered
        hs_cyc.delete();
        out_ready_i = 1'b0;
        drive(1'b1, 3'd0, 32'd11, 32'd2, 32'd0, 4'd7);
        drive(1'b1, 3'd0, 32'd12, 32'd2, 32'd0, 4'd8);
        flush_i = 1'b1;
        drive(1'b1, 3'd0, 32'd13, 32'd2, 32'd0, 4'd9);
        flush_i = 1'b0;
        chk("flush_valid", out_valid_o, 0);
        out_ready_i = 1'b1;
        idle(8);
        // Flush on an idle pipe while in_ready is high
        flush_i = 1'b1;
        drive(1'b1, 3'd0, 32'd14, 32'd2, 32'd0, 4'd10);
        flush_i = 1'b0;
        idle(8);
        chk("flush_no_results", hs_cyc.size(), 0);

        // Reserved op, then reset with a second op in flight
        hs_cyc.delete();
        drive(1'b1, 3'd6, 32'h1234_5678, 32'h9, 32'd1, 4'd9);
        idle(S);
        chk("resv_count", hs_cyc.size(), 1);
        drive(1'b1, 3'd0, 32'd5, 32'd5, 32'd0, 4'd10);
        rst_n = 1'b0;
        idle(1);
        chk("mrst_out_valid", out_valid_o, 0);
        chk("mrst_result",    result_o, 0);
        chk("mrst_tag",       tag_o, 0);
        chk("mrst_illegal",   illegal_o, 0);
        rst_n = 1'b1;
        idle(6);
        chk("mrst_no_result", hs_cyc.size(), 1);

`ifdef MUL_PIPE_SAT_EN
        drive(1'b1, 3'd5, 32'h7FFF_FFFF, 32'd2, 32'd0, 4'd1);
        drive(1'b1, 3'd5, 32'hFFFF_FFFD, 32'd4, 32'd2, 4'd2);
        drain();
`endif

        // Randomised traffic with back-pressure and occasional flush
        for (int i = 0; i < 800; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            op_i        = 3'($urandom_range(0, 7));
            operand_a_i = pick();
            operand_b_i = pick();
            operand_c_i = pick();
            tag_i       = 4'($urandom);
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
